// File: rtl/i2c_slave_regfile.sv
// Byte-level register bank behind an I2C slave core, plus a local port.
// Optional completion interrupt: define I2C_REGFILE_IRQ_EN.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         DEPTH      = 16,
  parameter int         AW         = 4
) (
  input  logic          clk,
  input  logic          reset,
  output logic [6:0]    address,
  input  logic          start,
  input  logic          rw,
  input  logic          stop,
  input  logic [7:0]    datareceive,
  input  logic          received,
  output logic [7:0]    datasend,
  input  logic          sended,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  input  logic          loc_we,
  output logic [7:0]    loc_rdata,
`ifdef I2C_REGFILE_IRQ_EN
  output logic          irq,
`endif
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PTR   = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    ds_q;
  logic [7:0]    lrd_q;
  logic          ds_load;
  logic [AW-1:0] ds_addr;
  logic          i2c_we;

  assign address   = SLAVE_ADDR;
  assign datasend  = ds_q;
  assign loc_rdata = lrd_q;
  assign busy      = (state_q != IDLE);

  // Bus events: start beats stop, stop beats byte events.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ds_load = 1'b0;
    ds_addr = ptr_q;
    i2c_we  = 1'b0;
    if (start) begin
      state_d = rw ? RDATA : PTR;
      ds_load = rw;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        PTR: if (received) begin
          ptr_d   = datareceive[AW-1:0];
          state_d = WDATA;
        end
        WDATA: if (received) begin
          i2c_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
        end
        RDATA: if (sended) begin
          ptr_d   = ptr_q + 1'b1;
          ds_addr = ptr_q + 1'b1;
          ds_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control state, pointer and outgoing byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ds_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (ds_load) ds_q <= mem_q[ds_addr];
    end
  end

  // Bank storage; the bus write wins a same-index clash.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i2c_we && ptr_q == AW'(i))
          mem_q[i] <= datareceive;
        else if (loc_we && loc_addr == AW'(i))
          mem_q[i] <= loc_wdata;
      end
    end
  end

  // Registered local read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lrd_q <= 8'h00;
    else        lrd_q <= mem_q[loc_addr];
  end

`ifdef I2C_REGFILE_IRQ_EN
  logic wr_q;
  logic irq_q;
  logic irq_clr;
  logic txn_end;

  assign irq     = irq_q;
  assign irq_clr = loc_we && (loc_addr == AW'(DEPTH - 1));
  assign txn_end = !start && stop && (state_q != IDLE);

  // Flag a finished transaction that stored at least one byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (state_q == IDLE) wr_q <= 1'b0;
      else if (i2c_we)     wr_q <= 1'b1;
      if (irq_clr)                irq_q <= 1'b0;
      else if (txn_end && wr_q)   irq_q <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Byte-level responder behind the I2C slave core: a register bank of DEPTH bytes that an external I2C master reads and writes.
- Fixed protocol: the first byte written after an addressed START is the register pointer; every following written byte goes to mem[ptr], then ptr auto-increments.
- Reads return mem[ptr] with auto-increment.
- A local fabric port gives on-chip logic direct read/write access to the same bank.

Parameters:
SLAVE_ADDR  7'h3C  own 7-bit I2C address, driven constantly on `address`
DEPTH       16     number of 8-bit registers; must be a power of two, 2..256
AW          4      pointer width, log2(DEPTH)

Ports:
clk         input   1   system clock
reset       input   1   asynchronous active-low reset
address     output  7   own slave address to the slave core (= SLAVE_ADDR)
start       input   1   one-clk pulse: address matched after START or repeated START
rw          input   1   R/W bit of the matched address byte, valid while start=1 (1 = master reads)
stop        input   1   one-clk pulse: STOP detected on the bus
datareceive input   8   byte received from the master, valid while received=1
received    input   1   one-clk pulse: byte received and ACKed
datasend    output  8   byte the slave core shifts out on the next master read
sended      input   1   one-clk pulse: datasend byte transmitted, next byte needed
loc_addr    input   AW  local port register index
loc_wdata   input   8   local write data
loc_we      input   1   local write enable, one clk per write
loc_rdata   output  8   mem[loc_addr], registered, 1-clk latency
busy        output  1   1 from an accepted start until stop or reset

Behaviour:
- Reset (reset=0, async): state=IDLE, ptr=0, all mem=8'h00, datasend=8'h00, loc_rdata=8'h00, busy=0, irq=0 (if built).
- address = SLAVE_ADDR at all times, including during reset.
- State machine:
  - IDLE: start & !rw -> PTR. start & rw -> RDATA; datasend <= mem[ptr] on the next clk. No start -> IDLE.
  - PTR: received -> ptr <= datareceive[AW-1:0] (upper bits ignored), go to WDATA. start -> re-enter per rw. stop -> IDLE.
  - WDATA: received -> mem[ptr] <= datareceive, ptr <= ptr+1. start (repeated START) -> PTR if !rw; RDATA if rw, with ptr preserved. stop -> IDLE.
  - RDATA: sended -> ptr <= ptr+1 and datasend <= mem[ptr+1] on the same edge. The slave core samples datasend no earlier than 1 clk after sended. stop -> IDLE. start -> re-enter per rw.
- Pointer arithmetic: ptr is AW bits and wraps DEPTH-1 -> 0 with no error. The pointer persists across transactions: a read that begins with a bare START+R continues from the last ptr.
- Precedence:
  - stop has priority over received or sended in the same clk; the byte is discarded and ptr is unchanged.
  - start has priority over stop.
  - received or sended in IDLE is ignored.
- Local port:
  - loc_rdata <= mem[loc_addr] every clk.
  - loc_we writes mem[loc_addr] <= loc_wdata.
  - If an I2C write and a loc_we hit the same index in the same clk, the I2C write wins and the local write is dropped. Different indices are both written.
  - A local write to mem[ptr] while in RDATA does not change an already-loaded datasend; it is seen on the next load.
- busy = (state != IDLE).
- Reset mid-transaction returns immediately to the reset values. The next transaction must begin with start.

Optional Feature:
- Macro: I2C_REGFILE_IRQ_EN.
- With the macro defined: adds output `irq` (1 bit), reset 0. irq is set 1 clk after the stop that ends a transaction in which at least one WDATA byte was written. irq is cleared by a loc_we to index DEPTH-1, or by reset. A write-pointer-only transaction (PTR then stop) does not set irq.
- Without the macro: no irq port and no related logic. All other behaviour is identical.

Test Plan:
1. Reset release -> address=7'h3C, datasend=0, busy=0, all loc_rdata reads return 8'h00.
2. start(rw=0), received 8'h05, received 8'hA1, received 8'hB2, stop -> mem[5]=8'hA1, mem[6]=8'hB2, ptr=7, busy falls 1 clk after stop.
3. After 2: start(rw=0), received 8'h05, start(rw=1) -> datasend=8'hA1. Pulse sended -> datasend=8'hB2, then mem[7]=8'h00.
4. start(rw=0), received 8'h0F, received 8'h11, received 8'h22 -> mem[15]=8'h11, mem[0]=8'h22 (wrap). Pointer byte 8'hF3 with DEPTH=16 -> ptr=3.
5. WDATA at ptr=4 with received and loc_we(loc_addr=4, 8'hEE) in the same clk, datareceive=8'h77 -> mem[4]=8'h77. Repeat with received and stop in the same clk -> mem unchanged, state=IDLE.
6. reset asserted mid-RDATA -> all outputs at reset values within the same clk. With I2C_REGFILE_IRQ_EN: the write in scenario 2 sets irq=1 after stop; loc_we to index 15 clears it.
